// File: rtl/alarm_pkg.sv
// Shared types and default widths for the burst-pattern alarm buzzer.
package alarm_pkg;

    localparam int CNT_W_DEF   = 26;
    localparam int BURST_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TONE   = 2'd1,
        GAP    = 2'd2,
        SNOOZE = 2'd3
    } state_t;

endpackage

// File: rtl/half_period_timer.sv
// Free-running half-period divider; pulses tick on the last count of each period.
module half_period_timer #(
    parameter int CNT_W = 26
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             run,
    input  logic [CNT_W-1:0] H,
    output logic             tick
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] last;

    // H of zero behaves like one: tick every cycle
    assign last = (H == '0) ? '0 : H - 1'b1;
    assign tick = run && (count == last);

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/alarm_pattern.sv
// Alarm buzzer: square-wave tone grouped into bursts with silent gaps and snooze.
module alarm_pattern
    import alarm_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int BURST_W       = BURST_W_DEF,
    parameter int SNOOZE_HALVES = 64
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               enable,
    input  logic [CNT_W-1:0]   half_period,
    input  logic [BURST_W-1:0] beeps,
    input  logic [BURST_W-1:0] gap_halves,
    input  logic               snooze,
    output logic               BUZZER,
    output logic               active
);

    localparam int SNZ_W = $clog2(SNOOZE_HALVES + 1);
    localparam logic [SNZ_W-1:0] SNZ_LAST = SNZ_W'(SNOOZE_HALVES - 1);

    state_t             state;
    logic [CNT_W-1:0]   hp;
    logic [BURST_W-1:0] bp;
    logic [BURST_W-1:0] gp;
    logic [BURST_W-1:0] beep_cnt;
    logic [BURST_W-1:0] gap_cnt;
    logic [SNZ_W-1:0]   snz_cnt;

    logic tick;
    logic run;
    logic clear;
    logic beep_done;
    logic gap_done;
    logic snz_done;

    assign run       = (state != IDLE);
    assign beep_done = (beep_cnt == bp - 1'b1);
    assign gap_done  = (gap_cnt == gp - 1'b1);
    assign snz_done  = (snz_cnt == SNZ_LAST);

    // Restart the half-period on every phase entry so each phase starts aligned
    assign clear = !run || !enable || snooze ||
                   (tick && state == GAP && gap_done) ||
                   (tick && state == SNOOZE && snz_done);

    half_period_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .CLK  (CLK),
        .RST  (RST),
        .clear(clear),
        .run  (run),
        .H    (hp),
        .tick (tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            BUZZER   <= 1'b0;
            active   <= 1'b0;
            hp       <= '0;
            bp       <= '0;
            gp       <= '0;
            beep_cnt <= '0;
            gap_cnt  <= '0;
            snz_cnt  <= '0;
        end else if (state == IDLE) begin
            BUZZER <= 1'b0;
            if (enable) begin
                state    <= TONE;
                active   <= 1'b1;
                hp       <= half_period;
                bp       <= beeps;
                gp       <= gap_halves;
                beep_cnt <= '0;
                gap_cnt  <= '0;
                snz_cnt  <= '0;
            end
        end else if (!enable) begin
            state    <= IDLE;
            active   <= 1'b0;
            BUZZER   <= 1'b0;
            beep_cnt <= '0;
            gap_cnt  <= '0;
            snz_cnt  <= '0;
        end else if (snooze) begin
            state   <= SNOOZE;
            BUZZER  <= 1'b0;
            snz_cnt <= '0;
        end else if (tick) begin
            unique case (state)
                TONE: begin
                    BUZZER <= ~BUZZER;
                    if (BUZZER && bp != '0) begin
                        if (beep_done) begin
                            beep_cnt <= '0;
                            if (gp != '0) begin
                                state   <= GAP;
                                gap_cnt <= '0;
                            end
                        end else begin
                            beep_cnt <= beep_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        state    <= TONE;
                        hp       <= half_period;
                        bp       <= beeps;
                        gp       <= gap_halves;
                        beep_cnt <= '0;
                        gap_cnt  <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                SNOOZE: begin
                    if (snz_done) begin
                        state    <= TONE;
                        hp       <= half_period;
                        bp       <= beeps;
                        gp       <= gap_halves;
                        beep_cnt <= '0;
                        snz_cnt  <= '0;
                    end else begin
                        snz_cnt <= snz_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alarm_pattern.md
Name: alarm_pattern

Overview:
- Parametrised successor to the single-tone enable-gated buzzer driver.
- Generates a square-wave BUZZER tone with a runtime-programmable half-period, grouped into bursts of N beeps separated by silent gaps, plus a snooze input.
- Sits between the clock/alarm-compare logic (drives `enable`) and the piezo output pin.

Parameters:
- CNT_W, 26, width of the half-period counter and of `half_period`.
- BURST_W, 4, width of the `beeps` and `gap_halves` inputs and their internal counters.
- SNOOZE_HALVES, 64, number of tone half-periods the output stays silent after a snooze pulse.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  synchronous active-high reset.
- enable  input  1  alarm request; level-sensitive.
- half_period  input  CNT_W  tone half-period in CLK cycles; 0 is treated as 1.
- beeps  input  BURST_W  beeps per burst; 0 means continuous tone with no gaps.
- gap_halves  input  BURST_W  silent half-periods between bursts; 0 means no gap.
- snooze  input  1  single-cycle pulse; silences the output temporarily.
- BUZZER  output  1  registered square-wave tone output.
- active  output  1  high whenever state != IDLE.

Behaviour:
- Reset: RST high at a clock edge forces state=IDLE, BUZZER=0, active=0, and all counters and latched settings to 0. RST has priority over every other input.
- States: IDLE, TONE, GAP, SNOOZE. Encoding is held in the package.
- Half-period tick: the timer counts 0..H-1, where H = max(latched half_period, 1). `tick` asserts on the cycle count==H-1, and the count then reloads to 0. The timer runs in TONE, GAP and SNOOZE, and is held at 0 in IDLE.
- IDLE -> TONE: on the first edge with enable=1. That edge latches half_period, beeps and gap_halves and clears the counters. BUZZER is still 0 on this edge.
- First toggle: BUZZER rises exactly H cycles after entering TONE. The counter restarts at 0 in TONE, so latency is H+1 clocks after enable is first sampled high.
- TONE:
  - Each tick toggles BUZZER.
  - Each 1->0 toggle completes one beep and increments beep_cnt.
  - When beep_cnt reaches the latched beeps (beeps != 0) on a falling toggle, go to GAP if gap_halves != 0; otherwise stay in TONE with beep_cnt cleared.
  - If beeps==0, the tone is continuous.
- GAP:
  - BUZZER is held 0; gap_cnt increments on each tick.
  - When gap_cnt reaches gap_halves: re-latch all three settings, clear the counters, return to TONE.
  - New settings therefore take effect only at burst boundaries, or on entry from IDLE.
- SNOOZE:
  - Entered from TONE or GAP on any edge with snooze=1 and enable=1.
  - BUZZER is forced 0, snz_cnt is cleared, and the timer is cleared.
  - snz_cnt increments per tick. At SNOOZE_HALVES, re-latch settings and enter TONE with beep_cnt=0.
  - A snooze pulse during SNOOZE restarts snz_cnt at 0. A snooze pulse in IDLE is ignored.
- enable falling: enable=0 in any non-IDLE state returns to IDLE on that edge, with BUZZER=0 and counters cleared. This takes priority over snooze and over tick.
- Simultaneous events:
  - tick and snooze in the same cycle: snooze wins, BUZZER=0.
  - Final-beep falling toggle and snooze together: go to SNOOZE.
- Widths:
  - beep_cnt and gap_cnt are BURST_W bits and never wrap, because the compare occurs first.
  - snz_cnt is clog2(SNOOZE_HALVES+1) bits.
- Mid-operation input changes: changes to half_period, beeps or gap_halves while in TONE have no effect until the next latch point.
- BUZZER and active are registered (no combinational path from inputs).

Decomposition:
- Package `alarm_pkg`: state enum (IDLE, TONE, GAP, SNOOZE) and the default constants for CNT_W and BURST_W.
- Sub-module `half_period_timer` (CNT_W): inputs CLK, RST, clear, run, H; output `tick`.
  - H=0 is clamped to 1.
  - `clear` has priority over `run`.
- The top level holds the FSM, the beep/gap/snooze counters and the setting latches.

Test Plan:
- Reset/idle: RST=1 for 3 cycles with enable=1 -> BUZZER=0, active=0 throughout. Release with enable=0 -> both stay 0.
- Continuous tone: half_period=4, beeps=0, enable rises at cycle 0 -> BUZZER rises at cycle 5, then toggles every 4 cycles. active=1 from cycle 1.
- Burst/gap: half_period=2, beeps=3, gap_halves=4 -> three high pulses of 2 cycles each, then BUZZER low for 8 cycles, then the pattern repeats. Changing beeps to 1 mid-burst takes effect only from the second burst.
- Snooze: SNOOZE_HALVES=4, half_period=3. Pulse snooze while BUZZER=1 -> BUZZER=0 next edge, stays 0 for 12 cycles, then resumes with the first rise 3 cycles later. A second pulse at cycle 6 of the snooze extends silence to 18 cycles total.
- Disable priority: enable=0 on the same edge as snooze and a tick -> state=IDLE, BUZZER=0, active=0. Re-enable -> first rise after H+1 cycles.
- Edge cases: half_period=0 -> BUZZER toggles every cycle. RST asserted mid-GAP -> all outputs 0 on the next edge, and re-entry starts a fresh burst.
